// File: rtl/ip_megarom2.sv
// ip_megarom2: MegaROM mapper with eight banking modes, four 8 KB page
// registers, SCC/SCC+ register windows and a request/acknowledge RAM port.
module ip_megarom2 #(
    parameter int                      ADDR_H_WIDTH = 1,
    parameter logic [ADDR_H_WIDTH-1:0] ADDR_H       = '0,
    parameter logic [7:0]              PAGE_MASK    = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   mode,
    input  logic [15:0]                  bus_address,
    input  logic                         bus_memory,
    input  logic                         bus_io,
    input  logic                         bus_read,
    input  logic                         bus_write,
    input  logic [7:0]                   bus_write_data,
    output logic                         bus_memory_cs,
    output logic                         bus_io_cs,
    output logic                         bus_read_ready,
    output logic [7:0]                   bus_read_data,
    output logic                         rd,
    output logic                         wr,
    input  logic                         busy,
    output logic [ADDR_H_WIDTH+20:0]     address,
    output logic [7:0]                   wdata,
    input  logic [7:0]                   rdata,
    input  logic                         rdata_en
);

    typedef enum logic [2:0] {IDLE, RREQ, RWAIT, WREQ, FILL} state_t;

    state_t                      state_q, state_d;
    logic [3:0][7:0]             page_q, page_d;
    logic                        sccp_en_q, sccp_en_d;
    logic                        sccp_ram_en_q, sccp_ram_en_d;
    logic [ADDR_H_WIDTH+20:0]    address_q, address_d;
    logic [7:0]                  wdata_q, wdata_d;
    logic [7:0]                  rdata_q, rdata_d;
    logic                        ready_q, ready_d;

    logic                        in_window;
    logic [2:0]                  sel_raw;
    logic [1:0]                  page_sel;
    logic [4:0]                  a5;
    logic [3:0]                  a4;
    logic [2:0]                  a3;
    logic                        wr_strobe;
    logic [7:0]                  val;
    logic [7:0]                  pair_lo;
    logic [7:0]                  pair_hi;
    logic                        scc_win;
    logic                        sccp_win;
    logic                        is_modereg;
    logic                        ram_wr_ok;
    logic [ADDR_H_WIDTH+20:0]    ram_addr;
    logic                        unused_bus_io;

    assign unused_bus_io = bus_io;

    // Address decode shared by page writes, window checks and the FSM
    always_comb begin
        a5         = bus_address[15:11];
        a4         = bus_address[15:12];
        a3         = bus_address[15:13];
        in_window  = (a3 == 3'b010) || (a3 == 3'b011) || (a3 == 3'b100) || (a3 == 3'b101);
        sel_raw    = a3 - 3'd2;
        page_sel   = sel_raw[1:0];
        wr_strobe  = bus_memory & bus_write;
        val        = bus_write_data & PAGE_MASK;
        pair_lo    = {bus_write_data[6:0], 1'b0} & PAGE_MASK;
        pair_hi    = {bus_write_data[6:0], 1'b1} & PAGE_MASK;
        scc_win    = ((mode == 3'd4) || (mode == 3'd5)) && (a5 == 5'b10011) && (page_q[2] == 8'h3F);
        sccp_win   = (mode == 3'd5) && (a5 == 5'b10111) && page_q[3][7];
        is_modereg = (bus_address[15:1] == 15'h5FFF);
        ram_wr_ok  = (mode == 3'd5) && sccp_ram_en_q && in_window && !scc_win && !sccp_win && !is_modereg;
        // RAM address uses the page values as they stood before this cycle's update
        ram_addr   = {ADDR_H, page_q[page_sel], bus_address[12:0]};
    end

    // Page-register and SCC-I mode register updates, on every write strobe
    always_comb begin
        page_d        = page_q;
        sccp_en_d     = sccp_en_q;
        sccp_ram_en_d = sccp_ram_en_q;
        if (wr_strobe) begin
            case (mode)
                3'd0: if (a5[4:2] == 3'b011) page_d[a5[1:0]] = val;
                3'd1: begin
                    if (a4 == 4'b0110) begin
                        page_d[0] = pair_lo;
                        page_d[1] = pair_hi;
                    end else if (a4 == 4'b0111) begin
                        page_d[2] = pair_lo;
                        page_d[3] = pair_hi;
                    end
                end
                3'd3: begin
                    case (a3)
                        3'b011:  page_d[1] = val;
                        3'b100:  page_d[2] = val;
                        3'b101:  page_d[3] = val;
                        default: ;
                    endcase
                end
                3'd4, 3'd5: begin
                    case (a5)
                        5'b01010: page_d[0] = val;
                        5'b01110: page_d[1] = val;
                        5'b10010: page_d[2] = val;
                        5'b10110: page_d[3] = val;
                        default:  ;
                    endcase
                    if ((mode == 3'd5) && is_modereg) begin
                        sccp_en_d     = bus_write_data[5];
                        sccp_ram_en_d = bus_write_data[4];
                    end
                end
                3'd6: begin
                    case (a5)
                        5'b01000: page_d[0] = val;
                        5'b01100: page_d[1] = val;
                        5'b10000: page_d[2] = val;
                        5'b10100: page_d[3] = val;
                        default:  ;
                    endcase
                end
                3'd7: begin
                    // Either Gen8 window of a page pair loads both pages of that pair
                    case (a5)
                        5'b01000, 5'b01100: begin
                            page_d[0] = pair_lo;
                            page_d[1] = pair_hi;
                        end
                        5'b10000, 5'b10100: begin
                            page_d[2] = pair_lo;
                            page_d[3] = pair_hi;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // RAM request/acknowledge FSM: next state and registered outputs
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_memory && bus_read && in_window) begin
                    if (scc_win || sccp_win) begin
                        state_d = FILL;
                    end else begin
                        address_d = ram_addr;
                        state_d   = RREQ;
                    end
                end else if (wr_strobe && ram_wr_ok) begin
                    address_d = ram_addr;
                    wdata_d   = bus_write_data;
                    state_d   = WREQ;
                end
            end
            RREQ:  if (!busy) state_d = RWAIT;
            RWAIT: begin
                if (rdata_en) begin
                    rdata_d = rdata;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WREQ:  if (!busy) state_d = IDLE;
            FILL: begin
                rdata_d = 8'hFF;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            page_q        <= {8'd3, 8'd2, 8'd1, 8'd0};
            sccp_en_q     <= 1'b0;
            sccp_ram_en_q <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            sccp_en_q     <= sccp_en_d;
            sccp_ram_en_q <= sccp_ram_en_d;
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            ready_q       <= ready_d;
        end
    end

    assign bus_memory_cs  = in_window;
    assign bus_io_cs      = 1'b0;
    assign bus_read_ready = ready_q;
    assign bus_read_data  = rdata_q;
    assign rd             = (state_q == RREQ);
    assign wr             = (state_q == WREQ);
    assign address        = address_q;
    assign wdata          = wdata_q;

endmodule

// File: tb/tb_ip_megarom2.sv
// Directed testbench for ip_megarom2: two instances (full and 1Fh page mask)
// share all inputs; expected values are hand-computed constants.
module tb_ip_megarom2;

    logic        clk;
    logic        reset;
    logic [2:0]  mode;
    logic [15:0] bus_address;
    logic        bus_memory, bus_io, bus_read, bus_write;
    logic [7:0]  bus_write_data;
    logic        busy;
    logic [7:0]  rdata;
    logic        rdata_en;

    logic        bus_memory_cs, bus_io_cs, bus_read_ready, rd, wr;
    logic [7:0]  bus_read_data, wdata;
    logic [21:0] address;

    logic        m_bus_memory_cs, m_bus_io_cs, m_bus_read_ready, m_rd, m_wr;
    logic [7:0]  m_bus_read_data, m_wdata;
    logic [21:0] m_address;

    int checks = 0;
    int errors = 0;

    ip_megarom2 #(.ADDR_H_WIDTH(1), .ADDR_H(1'b0), .PAGE_MASK(8'hFF)) dut (
        .clk(clk), .reset(reset), .mode(mode), .bus_address(bus_address),
        .bus_memory(bus_memory), .bus_io(bus_io), .bus_read(bus_read), .bus_write(bus_write),
        .bus_write_data(bus_write_data), .bus_memory_cs(bus_memory_cs), .bus_io_cs(bus_io_cs),
        .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data), .rd(rd), .wr(wr),
        .busy(busy), .address(address), .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en)
    );

    ip_megarom2 #(.ADDR_H_WIDTH(1), .ADDR_H(1'b0), .PAGE_MASK(8'h1F)) dut_m (
        .clk(clk), .reset(reset), .mode(mode), .bus_address(bus_address),
        .bus_memory(bus_memory), .bus_io(bus_io), .bus_read(bus_read), .bus_write(bus_write),
        .bus_write_data(bus_write_data), .bus_memory_cs(m_bus_memory_cs), .bus_io_cs(m_bus_io_cs),
        .bus_read_ready(m_bus_read_ready), .bus_read_data(m_bus_read_data), .rd(m_rd), .wr(m_wr),
        .busy(busy), .address(m_address), .wdata(m_wdata), .rdata(rdata), .rdata_en(rdata_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ra(input logic [7:0] pg, input logic [12:0] off);
        return {10'd0, 1'b0, pg, off};
    endfunction

    task automatic rd_strobe(input logic [15:0] a);
        bus_address = a;
        bus_memory  = 1'b1;
        bus_read    = 1'b1;
        @(negedge clk);
        bus_read    = 1'b0;
    endtask

    task automatic wr_strobe(input logic [15:0] a, input logic [7:0] d);
        bus_address    = a;
        bus_write_data = d;
        bus_memory     = 1'b1;
        bus_write      = 1'b1;
        @(negedge clk);
        bus_write      = 1'b0;
    endtask

    // Read with busy=0 and rdata_en on the first RWAIT cycle: ready 3 cycles after strobe
    task automatic read_txn(input string tag, input logic [15:0] a, input logic [7:0] v,
                            input logic [31:0] exp_a, input logic [31:0] exp_am);
        rd_strobe(a);
        check({tag, "_rd"}, {31'd0, rd}, 32'd1);
        check({tag, "_addr"}, {10'd0, address}, exp_a);
        check({tag, "_addr_m"}, {10'd0, m_address}, exp_am);
        @(negedge clk);
        check({tag, "_rd_drop"}, {31'd0, rd}, 32'd0);
        rdata    = v;
        rdata_en = 1'b1;
        @(negedge clk);
        rdata_en = 1'b0;
        check({tag, "_ready"}, {31'd0, bus_read_ready}, 32'd1);
        check({tag, "_data"}, {24'd0, bus_read_data}, {24'd0, v});
        @(negedge clk);
        check({tag, "_ready_end"}, {31'd0, bus_read_ready}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; mode = 3'd0; bus_address = 16'h4123;
        bus_memory = 1'b0; bus_io = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
        bus_write_data = 8'h00; busy = 1'b0; rdata = 8'h00; rdata_en = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_rd", {31'd0, rd}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_ready", {31'd0, bus_read_ready}, 32'd0);
        check("rst_data", {24'd0, bus_read_data}, 32'd0);
        check("rst_addr", {10'd0, address}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("io_cs", {31'd0, bus_io_cs}, 32'd0);
        check("mem_cs_in", {31'd0, bus_memory_cs}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // ASC8 read at 4123h, page0=0
        read_txn("asc8_4123", 16'h4123, 8'h5A, ra(8'h00, 13'h0123), ra(8'h00, 13'h0123));

        // ASC8 page1 write at 6800h, then read in page1 on the very next cycle
        wr_strobe(16'h6800, 8'h07);
        read_txn("asc8_p1", 16'h6004, 8'h3C, ra(8'h07, 13'h0004), ra(8'h07, 13'h0004));

        // Outside the 4000h-BFFFh window: ignored
        rd_strobe(16'h3000);
        check("oow_cs", {31'd0, bus_memory_cs}, 32'd0);
        check("oow_rd", {31'd0, rd}, 32'd0);
        @(negedge clk);

        // ASC16: 05h at 7000h -> page2=0Ah, page3=0Bh
        mode = 3'd1;
        wr_strobe(16'h7000, 8'h05);
        read_txn("asc16_8010", 16'h8010, 8'h11, ra(8'h0A, 13'h0010), ra(8'h0A, 13'h0010));
        read_txn("asc16_A010", 16'hA010, 8'h22, ra(8'h0B, 13'h0010), ra(8'h0B, 13'h0010));

        // Gen8: FFh at 8000h -> page2=FFh (full mask) / 1Fh (mask 1Fh)
        mode = 3'd6;
        wr_strobe(16'h8000, 8'hFF);
        read_txn("gen8_mask", 16'h8000, 8'h33, ra(8'hFF, 13'h0000), ra(8'h1F, 13'h0000));

        // busy held 4 cycles in RREQ: rd high 5 cycles, address stable
        mode = 3'd0;
        busy = 1'b1;
        rd_strobe(16'h6000);
        for (int i = 0; i < 5; i++) begin
            check("busy_rd", {31'd0, rd}, 32'd1);
            check("busy_addr", {10'd0, address}, ra(8'h07, 13'h0000));
            if (i == 4) busy = 1'b0;
            @(negedge clk);
        end
        check("busy_rd_drop", {31'd0, rd}, 32'd0);
        // Second read strobe during RWAIT is ignored
        rd_strobe(16'h6000);
        check("rwait_strobe_rd", {31'd0, rd}, 32'd0);
        rdata    = 8'hC3;
        rdata_en = 1'b1;
        @(negedge clk);
        rdata_en = 1'b0;
        check("busy_ready", {31'd0, bus_read_ready}, 32'd1);
        check("busy_data", {24'd0, bus_read_data}, 32'h0000_00C3);
        @(negedge clk);
        check("busy_idle_rd", {31'd0, rd}, 32'd0);
        check("busy_idle_ready", {31'd0, bus_read_ready}, 32'd0);

        // rdata_en in IDLE is ignored
        rdata    = 8'h77;
        rdata_en = 1'b1;
        @(negedge clk);
        rdata_en = 1'b0;
        check("idle_en_ready", {31'd0, bus_read_ready}, 32'd0);
        check("idle_en_data", {24'd0, bus_read_data}, 32'h0000_00C3);

        // SCC: 3Fh at 9000h opens 9800h window -> FILL, FFh, ready 2 cycles after strobe
        mode = 3'd4;
        wr_strobe(16'h9000, 8'h3F);
        rd_strobe(16'h9800);
        check("scc_rd", {31'd0, rd}, 32'd0);
        check("scc_ready_early", {31'd0, bus_read_ready}, 32'd0);
        @(negedge clk);
        check("scc_ready", {31'd0, bus_read_ready}, 32'd1);
        check("scc_data", {24'd0, bus_read_data}, 32'h0000_00FF);
        @(negedge clk);
        check("scc_ready_end", {31'd0, bus_read_ready}, 32'd0);

        // SCC+: enable RAM writes, write AAh to 8100h
        mode = 3'd5;
        wr_strobe(16'hBFFE, 8'h10);
        check("sccp_modereg_wr", {31'd0, wr}, 32'd0);
        wr_strobe(16'h8100, 8'hAA);
        check("sccp_wr", {31'd0, wr}, 32'd1);
        check("sccp_wdata", {24'd0, wdata}, 32'h0000_00AA);
        check("sccp_waddr", {10'd0, address}, ra(8'h3F, 13'h0100));
        @(negedge clk);
        check("sccp_wr_drop", {31'd0, wr}, 32'd0);
        // Disable RAM writes: further write blocked
        wr_strobe(16'hBFFE, 8'h00);
        wr_strobe(16'h8100, 8'h55);
        check("sccp_blocked_wr", {31'd0, wr}, 32'd0);
        check("sccp_blocked_wdata", {24'd0, wdata}, 32'h0000_00AA);
        @(negedge clk);

        // Reset during RREQ aborts; no ready afterwards
        mode = 3'd0;
        busy = 1'b1;
        rd_strobe(16'h4000);
        check("abort_rd_pre", {31'd0, rd}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rd", {31'd0, rd}, 32'd0);
        check("abort_addr", {10'd0, address}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        busy     = 1'b0;
        rdata    = 8'h99;
        rdata_en = 1'b1;
        @(negedge clk);
        rdata_en = 1'b0;
        check("abort_ready", {31'd0, bus_read_ready}, 32'd0);
        @(negedge clk);
        check("abort_ready2", {31'd0, bus_read_ready}, 32'd0);
        check("abort_data", {24'd0, bus_read_data}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
